nop_stage_register: RTL and testbench
=====================================

# nop_stage_register

Parametrised pipeline-stage register with NOP insertion for the MIPS pipeline. It sits between two adjacent stages (e.g. D→E) and forwards instruction and PC each cycle. It holds its contents on stall and replaces the instruction with a NOP on flush. It can also issue a counted burst of back-to-back NOPs for multi-cycle hazards and exception entry, and it keeps a saturating count of inserted bubbles for performance debug.

## Interface
- WIDTH, 32, instruction width in bits
- PC_WIDTH, 32, PC width in bits
- NOP_VALUE, 32'd0 (WIDTH bits), encoding driven as a bubble
- BURST_W, 3, width of burst length; max burst = 2^BURST_W − 1
- CNT_W, 16, width of bubble statistics counter

- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- instr_in  in  WIDTH  instruction from upstream stage
- pc_in  in  PC_WIDTH  PC from upstream stage
- stall  in  1  hold current contents
- flush  in  1  replace next content with NOP, abort any burst
- burst_req  in  1  request NOP burst
- burst_len  in  BURST_W  number of NOPs in burst (0 = no-op)
- instr_out  out  WIDTH  registered instruction to downstream
- pc_out  out  PC_WIDTH  registered PC to downstream
- is_bubble  out  1  registered; 1 when instr_out is an inserted NOP
- burst_busy  out  1  combinational; 1 while remaining burst count ≠ 0
- bubble_count  out  CNT_W  saturating count of inserted NOPs

## Operation
- State: instr_q, pc_q, bubble_q, rem (BURST_W bits), cnt (CNT_W bits).
- Per-edge priority, highest first:
  1. reset: instr_q=NOP_VALUE, pc_q=0, bubble_q=1, rem=0, cnt=0.
  2. flush: instr_q=NOP_VALUE, pc_q=pc_in, bubble_q=1, rem=0.
  3. rem≠0: instr_q=NOP_VALUE, pc_q=pc_in, bubble_q=1, rem=rem−1.
  4. burst_req && burst_len≠0: instr_q=NOP_VALUE, pc_q=pc_in, bubble_q=1, rem=burst_len−1.
  5. stall: all registers hold.
  6. otherwise: instr_q=instr_in, pc_q=pc_in, bubble_q=0.
- burst_req is ignored while rem≠0 and when burst_len=0; requests are never queued.
- flush during a burst terminates it; if flush and burst_req arrive together, flush wins and no burst starts.
- A burst overrides stall: a stalled stage still issues the remaining NOPs. Upstream must itself stall while burst_busy=1. The block does not hold upstream.
- PC is captured on every NOP insertion, so downstream exception logic sees the victim PC.
- cnt increments by 1 on every edge where cases 2–4 apply. It saturates at 2^CNT_W−1, and only reset clears it.
- Outputs: instr_out=instr_q, pc_out=pc_q, is_bubble=bubble_q, bubble_count=cnt, burst_busy=(rem≠0).

## Timing
- Latency: 1 cycle from inputs to outputs. No combinational path from instr_in/pc_in to outputs.
- burst_busy is combinational from rem only, with no path from inputs.
- Burst of N started at edge k: NOPs appear on outputs after edges k..k+N−1. burst_busy is high in the N−1 cycles following edge k. The first non-NOP load is at edge k+N.
- Reset values: instr_out=NOP_VALUE, pc_out=0, is_bubble=1, burst_busy=0, bubble_count=0. Reset asserted mid-burst clears rem on the same edge.
- stall held indefinitely keeps outputs constant, including is_bubble, and cnt does not change.
- burst_len=1: one NOP, burst_busy never asserts.

## Test plan
- Reset then stream 0x24010001@pc 0x3000, 0x24020002@0x3004 → outputs follow one cycle later, is_bubble=0; before the first load, instr_out=0, pc_out=0, is_bubble=1, bubble_count=0.
- Load 0x8C220004@0x3008, assert stall 3 cycles with instr_in changing → outputs hold 0x8C220004/0x3008 for all 3 cycles, bubble_count unchanged.
- flush with instr_in=0x00221820, pc_in=0x300C → next cycle instr_out=0, pc_out=0x300C, is_bubble=1, bubble_count+1.
- burst_req, burst_len=4 at edge k, stall asserted throughout, second burst_req at k+1 → NOPs after edges k..k+3, burst_busy high for exactly 3 cycles, bubble_count+4, second request ignored.
- burst_len=5 started, flush on its 2nd cycle → rem=0 after that edge, burst_busy drops, next unstalled edge loads instr_in, total bubbles +2. Repeat with reset instead of flush → all reset values.
- CNT_W=4, force 20 insertions → bubble_count saturates at 15 and stays there.

Source files
------------

// File: rtl/nop_stage_register.sv
// Pipeline-stage register between two MIPS stages: forwards instruction/PC,
// holds on stall, injects single NOPs on flush or counted NOP bursts.
module nop_stage_register #(
  parameter int                 WIDTH     = 32,
  parameter int                 PC_WIDTH  = 32,
  parameter logic [WIDTH-1:0]   NOP_VALUE = '0,
  parameter int                 BURST_W   = 3,
  parameter int                 CNT_W     = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [WIDTH-1:0]    instr_in,
  input  logic [PC_WIDTH-1:0] pc_in,
  input  logic                stall,
  input  logic                flush,
  input  logic                burst_req,
  input  logic [BURST_W-1:0]  burst_len,
  output logic [WIDTH-1:0]    instr_out,
  output logic [PC_WIDTH-1:0] pc_out,
  output logic                is_bubble,
  output logic                burst_busy,
  output logic [CNT_W-1:0]    bubble_count
);

  logic [WIDTH-1:0]    instr_q, instr_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic                bubble_q, bubble_d;
  logic [BURST_W-1:0]  rem_q, rem_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                insert;

  // Priority: flush > burst in progress > new burst > stall > normal load.
  always_comb begin
    instr_d  = instr_q;
    pc_d     = pc_q;
    bubble_d = bubble_q;
    rem_d    = rem_q;
    insert   = 1'b0;
    if (flush) begin
      insert = 1'b1;
      rem_d  = '0;
    end else if (rem_q != '0) begin
      insert = 1'b1;
      rem_d  = rem_q - BURST_W'(1);
    end else if (burst_req && (burst_len != '0)) begin
      insert = 1'b1;
      rem_d  = burst_len - BURST_W'(1);
    end else if (!stall) begin
      instr_d  = instr_in;
      pc_d     = pc_in;
      bubble_d = 1'b0;
    end
    if (insert) begin
      instr_d  = NOP_VALUE;
      pc_d     = pc_in;
      bubble_d = 1'b1;
    end
  end

  // Bubble statistics saturate rather than wrap so long runs stay meaningful.
  always_comb begin
    cnt_d = cnt_q;
    if (insert && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q  <= NOP_VALUE;
      pc_q     <= '0;
      bubble_q <= 1'b1;
      rem_q    <= '0;
      cnt_q    <= '0;
    end else begin
      instr_q  <= instr_d;
      pc_q     <= pc_d;
      bubble_q <= bubble_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
    end
  end

  assign instr_out    = instr_q;
  assign pc_out       = pc_q;
  assign is_bubble    = bubble_q;
  assign bubble_count = cnt_q;
  assign burst_busy   = (rem_q != '0);

endmodule

// File: tb/tb_nop_stage_register.sv
// Scoreboard bench for nop_stage_register: directed vectors push expected
// outputs, a negedge monitor pops and compares against the DUT.
module tb_nop_stage_register;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instr_in = '0;
  logic [31:0] pc_in = '0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        burst_req = 1'b0;
  logic [2:0]  burst_len = '0;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        is_bubble;
  logic        burst_busy;
  logic [15:0] bubble_count;

  logic        sat_flush = 1'b0;
  logic        sat_stall = 1'b0;
  logic        sat_breq = 1'b0;
  logic [31:0] sat_instr_out;
  logic [31:0] sat_pc_out;
  logic        sat_is_bubble;
  logic        sat_busy;
  logic [3:0]  sat_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        bub;
    logic        busy;
    logic [15:0] cnt;
    string       name;
  } exp_t;

  exp_t       exp_q[$];
  logic [3:0] sat_q[$];

  always #5 clk = ~clk;

  nop_stage_register dut (
    .clk(clk), .reset(reset), .instr_in(instr_in), .pc_in(pc_in),
    .stall(stall), .flush(flush), .burst_req(burst_req), .burst_len(burst_len),
    .instr_out(instr_out), .pc_out(pc_out), .is_bubble(is_bubble),
    .burst_busy(burst_busy), .bubble_count(bubble_count)
  );

  nop_stage_register #(.CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset), .instr_in(instr_in), .pc_in(pc_in),
    .stall(sat_stall), .flush(sat_flush), .burst_req(sat_breq), .burst_len(burst_len),
    .instr_out(sat_instr_out), .pc_out(sat_pc_out), .is_bubble(sat_is_bubble),
    .burst_busy(sat_busy), .bubble_count(sat_count)
  );

  // Monitor: every edge produces an output, compared on the following negedge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (instr_out !== e.instr || pc_out !== e.pc || is_bubble !== e.bub ||
          burst_busy !== e.busy || bubble_count !== e.cnt) begin
        errors++;
        $display("FAIL %s: got instr=%h pc=%h bub=%b busy=%b cnt=%0d, required instr=%h pc=%h bub=%b busy=%b cnt=%0d",
                 e.name, instr_out, pc_out, is_bubble, burst_busy, bubble_count,
                 e.instr, e.pc, e.bub, e.busy, e.cnt);
      end else begin
        $display("txn %s: instr=%h pc=%h bub=%b busy=%b cnt=%0d ok",
                 e.name, instr_out, pc_out, is_bubble, burst_busy, bubble_count);
      end
    end
    if (sat_q.size() > 0) begin
      logic [3:0] ec;
      ec = sat_q.pop_front();
      checks++;
      if (sat_count !== ec) begin
        errors++;
        $display("FAIL sat_count: got %0d, required %0d", sat_count, ec);
      end else begin
        $display("txn sat: bubble_count=%0d ok", sat_count);
      end
    end
  end

  task automatic step(input logic rst, input logic fl, input logic st, input logic br,
                      input logic [2:0] bl, input logic [31:0] ins, input logic [31:0] pc,
                      input logic [31:0] e_instr, input logic [31:0] e_pc, input logic e_bub,
                      input logic e_busy, input logic [15:0] e_cnt, input string name);
    exp_t e;
    reset = rst; flush = fl; stall = st; burst_req = br; burst_len = bl;
    instr_in = ins; pc_in = pc;
    @(posedge clk);
    e.instr = e_instr; e.pc = e_pc; e.bub = e_bub; e.busy = e_busy; e.cnt = e_cnt;
    e.name = name;
    exp_q.push_back(e);
    #1;
  endtask

  task automatic sat_step(input logic fl, input logic [3:0] e_cnt);
    reset = 1'b0; flush = 1'b0; stall = 1'b1; burst_req = 1'b0;
    sat_flush = fl;
    @(posedge clk);
    sat_q.push_back(e_cnt);
    #1;
  endtask

  initial begin
    //    rst fl st br len instr        pc           e_instr      e_pc        bub busy cnt
    step(1, 0, 0, 0, 0, 32'h0,        32'h0,       32'h0,       32'h0,      1, 0, 0, "reset0");
    step(1, 0, 0, 0, 0, 32'h0,        32'h0,       32'h0,       32'h0,      1, 0, 0, "reset1");
    step(0, 0, 0, 0, 0, 32'h24010001, 32'h3000,    32'h24010001,32'h3000,   0, 0, 0, "load0");
    step(0, 0, 0, 0, 0, 32'h24020002, 32'h3004,    32'h24020002,32'h3004,   0, 0, 0, "load1");
    step(0, 0, 0, 0, 0, 32'h8C220004, 32'h3008,    32'h8C220004,32'h3008,   0, 0, 0, "load2");
    step(0, 0, 1, 0, 0, 32'h11111111, 32'h4000,    32'h8C220004,32'h3008,   0, 0, 0, "stall0");
    step(0, 0, 1, 0, 0, 32'h22222222, 32'h4004,    32'h8C220004,32'h3008,   0, 0, 0, "stall1");
    step(0, 0, 1, 0, 0, 32'h33333333, 32'h4008,    32'h8C220004,32'h3008,   0, 0, 0, "stall2");
    step(0, 1, 0, 0, 0, 32'h00221820, 32'h300C,    32'h0,       32'h300C,   1, 0, 1, "flush");
    // burst of 4 under stall; second request at k+1 must be ignored
    step(0, 0, 1, 1, 4, 32'h11,       32'h3010,    32'h0,       32'h3010,   1, 1, 2, "burst4_k");
    step(0, 0, 1, 1, 4, 32'h12,       32'h3014,    32'h0,       32'h3014,   1, 1, 3, "burst4_k1");
    step(0, 0, 1, 0, 0, 32'h13,       32'h3018,    32'h0,       32'h3018,   1, 1, 4, "burst4_k2");
    step(0, 0, 1, 0, 0, 32'h14,       32'h301C,    32'h0,       32'h301C,   1, 0, 5, "burst4_k3");
    step(0, 0, 1, 0, 0, 32'h15,       32'h5000,    32'h0,       32'h301C,   1, 0, 5, "post_burst_stall");
    step(0, 0, 0, 0, 0, 32'h00221820, 32'h3020,    32'h00221820,32'h3020,   0, 0, 5, "post_burst_load");
    // burst of 5 cut by flush on its second cycle
    step(0, 0, 0, 1, 5, 32'h16,       32'h3024,    32'h0,       32'h3024,   1, 1, 6, "burst5_k");
    step(0, 1, 0, 0, 0, 32'h17,       32'h3028,    32'h0,       32'h3028,   1, 0, 7, "burst5_flush");
    step(0, 0, 0, 0, 0, 32'h24030003, 32'h302C,    32'h24030003,32'h302C,   0, 0, 7, "after_flush_load");
    // same, cut by reset
    step(0, 0, 0, 1, 5, 32'h18,       32'h3030,    32'h0,       32'h3030,   1, 1, 8, "burst5b_k");
    step(1, 0, 0, 1, 5, 32'h19,       32'h3034,    32'h0,       32'h0,      1, 0, 0, "burst5b_reset");
    step(0, 0, 0, 0, 0, 32'h24040004, 32'h3034,    32'h24040004,32'h3034,   0, 0, 0, "after_reset_load");
    // burst_len=1, burst_len=0, flush+burst_req together
    step(0, 0, 0, 1, 1, 32'h1A,       32'h3038,    32'h0,       32'h3038,   1, 0, 1, "burst1");
    step(0, 0, 0, 0, 0, 32'h24050005, 32'h303C,    32'h24050005,32'h303C,   0, 0, 1, "burst1_after");
    step(0, 0, 0, 1, 0, 32'h24060006, 32'h3040,    32'h24060006,32'h3040,   0, 0, 1, "burst0_ignored");
    step(0, 1, 0, 1, 3, 32'h1B,       32'h3044,    32'h0,       32'h3044,   1, 0, 2, "flush_beats_burst");
    step(0, 0, 0, 0, 0, 32'h24070007, 32'h3048,    32'h24070007,32'h3048,   0, 0, 2, "flush_burst_after");
    step(0, 1, 0, 0, 0, 32'h1C,       32'h304C,    32'h0,       32'h304C,   1, 0, 3, "flush2");
    step(0, 0, 1, 0, 0, 32'h1D,       32'h3050,    32'h0,       32'h304C,   1, 0, 3, "stall_bubble0");
    step(0, 0, 1, 0, 0, 32'h1E,       32'h3054,    32'h0,       32'h304C,   1, 0, 3, "stall_bubble1");

    // Saturation on the 4-bit counter instance: 20 flushes, then idle edges.
    for (int i = 0; i < 20; i++) begin
      sat_step(1'b1, (i + 1 > 15) ? 4'd15 : 4'(i + 1));
    end
    sat_step(1'b0, 4'd15);
    sat_step(1'b0, 4'd15);
    sat_flush = 1'b0;

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || sat_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d/%0d pending, required 0/0", exp_q.size(), sat_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
